user_led_driver: RTL and testbench
==================================

USER_LED_DRIVER -- requirements
Module: user_led_driver

Interface
REQ-001 Parameter pTickDiv, default 1000, meaning iSysClk cycles per PWM tick (minimum 2).
REQ-002 Parameter pBlinkPeriods, default 32, meaning PWM periods per blink phase (minimum 1).
REQ-003 Parameter pBreathStep, default 4, meaning PWM periods per breathe level step (minimum 1).
REQ-004 Port iSysClk input 1, meaning the single system clock; all logic SHALL be synchronous to it.
REQ-005 Port iSysRst input 1, meaning reset, asynchronous assert, active-low.
REQ-006 Port iLedMode input 8, meaning 2-bit mode per LED; LED n uses bits [2n+1:2n]; 00 OFF, 01 ON, 10 BLINK, 11 BREATHE.
REQ-007 Port iLedDuty input 4, meaning the shared duty level for ON and BLINK modes.
REQ-008 Port iCfgVld input 1, meaning a configuration request; sampled together with iLedMode and iLedDuty.
REQ-009 Port oCfgBusy output 1, meaning an accepted configuration has not yet been applied.
REQ-010 Port oUserLed output 4, meaning registered, active-high drive to the external LEDs.

Function
REQ-011 The prescaler SHALL count 0..pTickDiv-1 and SHALL emit a one-cycle tick when it wraps.
REQ-012 A 4-bit pwm_cnt SHALL increment on each tick and wrap 15->0; the period boundary is defined as a tick with pwm_cnt==15.
REQ-013 Handshake: iCfgVld with oCfgBusy=0 SHALL latch iLedMode and iLedDuty into shadow registers and set oCfgBusy=1 on the next cycle.
REQ-014 iCfgVld with oCfgBusy=1 SHALL be ignored, with no shadow update.
REQ-015 At the period boundary, the active registers SHALL load from the shadow registers and oCfgBusy SHALL clear in the same cycle; a new iCfgVld in that cycle SHALL be accepted.
REQ-016 LED level: OFF=0; ON=(pwm_cnt<duty); BLINK=(pwm_cnt<duty) AND blink_phase; BREATHE=(pwm_cnt<br_level).
REQ-017 Duty arithmetic: duty 0 SHALL give a constant 0 output; duty 15 SHALL give 15 of 16 ticks high; the output SHALL never be constantly 1.
REQ-018 Blink: a period counter SHALL toggle blink_phase every pBlinkPeriods boundaries; blink_phase is shared by all LEDs and free-running regardless of mode.
REQ-019 Breathe FSM states: BR_UP and BR_DOWN; br_level is 4 bits and changes only every pBreathStep boundaries.
REQ-020 In BR_UP, br_level SHALL increment; on reaching 15 the FSM SHALL move to BR_DOWN. In BR_DOWN, br_level SHALL decrement; on reaching 0 the FSM SHALL move to BR_UP. There SHALL be no overflow or underflow.
REQ-021 oUserLed SHALL be registered, with one-cycle latency from pwm_cnt/level; changes SHALL occur only on tick edges, so there are no glitches.
REQ-022 A mode change SHALL take effect only at a period boundary, so there are no partial PWM periods.

Reset
REQ-023 iSysRst=0 SHALL immediately force oUserLed=0 and oCfgBusy=0.
REQ-024 Reset SHALL clear the prescaler, pwm_cnt, period counters, blink_phase and br_level, set the FSM to BR_UP, set all modes to OFF and duty to 0.
REQ-025 Reset asserted mid-operation SHALL discard any pending shadow configuration.
REQ-026 Release SHALL resume counting on the first clock edge after deassertion.

Structure
REQ-027 A shared package SHALL hold the mode enum (LED_OFF/ON/BLINK/BREATHE), the breathe state enum, and localparams for the PWM width (4) and LED count (4).
REQ-028 One sub-module, led_pwm_ch, SHALL be instantiated 4 times; it takes mode, duty, br_level, blink_phase and pwm_cnt, and produces the registered LED bit.
REQ-029 The prescaler, config handshake, blink counter and breathe FSM SHALL live in the top level.

Verification (pTickDiv=2, pBlinkPeriods=2, pBreathStep=1)
REQ-030 Reset during BREATHE -> oUserLed=0 within the same cycle; br_level=0 and BR_UP after release.
REQ-031 Configure all ON, duty=8 -> after the boundary, each LED is high for 8 of 16 ticks (16 of 32 clocks); oCfgBusy pulses from the cycle after iCfgVld until the boundary.
REQ-032 duty=0 -> oUserLed never 1; duty=15 -> exactly 15 of 16 ticks high per period.
REQ-033 A second iCfgVld (duty=3) while busy -> ignored; the first configuration (duty=8) is applied.
REQ-034 LED0 BLINK duty=15, others OFF -> LED0 pattern alternates 2 periods PWM / 2 periods dark; LED1-3 stay 0.
REQ-035 BREATHE -> br_level sequence per boundary 0,1,...,15,14,...,0,1, with no repeated 15 or 0 beyond a single period.

Source files
------------

// File: rtl/user_led_driver_pkg.sv
// Shared types and sizing for the user LED driver.
//   ledMode_t : per-LED drive mode (2 bits per LED on iLedMode)
//   brState_t : direction of the shared breathe ramp
//   PWM_W     : PWM counter / duty / breathe level width
//   LED_CNT   : number of LED channels
package user_led_driver_pkg;

  localparam int unsigned PWM_W   = 4;
  localparam int unsigned LED_CNT = 4;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_ON      = 2'b01,
    LED_BLINK   = 2'b10,
    LED_BREATHE = 2'b11
  } ledMode_t;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } brState_t;

endpackage

// File: rtl/user_led_driver_pwm_ch.sv
// One LED channel: compares the shared PWM count against this channel's
// level and registers the result.
//   iSysClk, iSysRst : clock, async active-low reset
//   iMode            : channel mode (OFF/ON/BLINK/BREATHE)
//   iDuty            : shared duty for ON and BLINK
//   iBrLevel         : shared breathe level
//   iBlinkPhase      : shared blink phase (1 = lit half)
//   iPwmCnt          : shared PWM position within the period
//   oLed             : registered LED drive, active high
module led_pwm_ch
  import user_led_driver_pkg::*;
(
  input  logic             iSysClk,
  input  logic             iSysRst,
  input  ledMode_t         iMode,
  input  logic [PWM_W-1:0] iDuty,
  input  logic [PWM_W-1:0] iBrLevel,
  input  logic             iBlinkPhase,
  input  logic [PWM_W-1:0] iPwmCnt,
  output logic             oLed
);

  logic ledNext;

  // Strict less-than: duty 0 is always dark, duty 15 lights 15 of 16 steps.
  always_comb begin
    ledNext = 1'b0;
    case (iMode)
      LED_OFF:     ledNext = 1'b0;
      LED_ON:      ledNext = (iPwmCnt < iDuty);
      LED_BLINK:   ledNext = (iPwmCnt < iDuty) && iBlinkPhase;
      LED_BREATHE: ledNext = (iPwmCnt < iBrLevel);
      default:     ledNext = 1'b0;
    endcase
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      oLed <= 1'b0;
    end else begin
      oLed <= ledNext;
    end
  end

endmodule

// File: rtl/user_led_driver.sv
// Four-channel user LED driver with PWM dimming, blink and breathe modes.
// Configuration is double-buffered: a request lands in shadow registers and
// is applied at the next PWM period boundary.
//   iSysClk   : system clock
//   iSysRst   : async active-low reset
//   iLedMode  : 2-bit mode per LED, LED n on bits [2n+1:2n]
//   iLedDuty  : shared duty for ON and BLINK
//   iCfgVld   : configuration request, sampled with iLedMode/iLedDuty
//   oCfgBusy  : accepted configuration not yet applied
//   oUserLed  : registered LED drive, active high
module user_led_driver
  import user_led_driver_pkg::*;
#(
  parameter int unsigned pTickDiv      = 1000,
  parameter int unsigned pBlinkPeriods = 32,
  parameter int unsigned pBreathStep   = 4
) (
  input  logic                 iSysClk,
  input  logic                 iSysRst,
  input  logic [2*LED_CNT-1:0] iLedMode,
  input  logic [PWM_W-1:0]     iLedDuty,
  input  logic                 iCfgVld,
  output logic                 oCfgBusy,
  output logic [LED_CNT-1:0]   oUserLed
);

  localparam int unsigned TICK_W  = (pTickDiv > 1)      ? $clog2(pTickDiv)      : 1;
  localparam int unsigned BLINK_W = (pBlinkPeriods > 1) ? $clog2(pBlinkPeriods) : 1;
  localparam int unsigned STEP_W  = (pBreathStep > 1)   ? $clog2(pBreathStep)   : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(pTickDiv - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(pBlinkPeriods - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(pBreathStep - 1);

  logic [TICK_W-1:0]  prescCnt;
  logic               tick;
  logic [PWM_W-1:0]   pwmCnt;
  logic               boundary;

  logic [BLINK_W-1:0] blinkCnt;
  logic               blinkPhase;

  logic [STEP_W-1:0]  stepCnt;
  logic               brStep;
  brState_t           brState, brStateNext;
  logic [PWM_W-1:0]   brLevel, brLevelNext;

  logic [2*LED_CNT-1:0]         shadowMode;
  logic [PWM_W-1:0]             shadowDuty;
  ledMode_t [LED_CNT-1:0]       activeMode;
  logic [PWM_W-1:0]             activeDuty;
  logic                         cfgAccept;

  assign tick     = (prescCnt == TICK_LAST);
  assign boundary = tick && (pwmCnt == '1);
  assign brStep   = boundary && (stepCnt == STEP_LAST);

  // Prescaler and PWM position
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      prescCnt <= '0;
      pwmCnt   <= '0;
    end else begin
      prescCnt <= tick ? '0 : prescCnt + TICK_W'(1);
      if (tick) begin
        pwmCnt <= pwmCnt + PWM_W'(1);
      end
    end
  end

  // Blink phase: free-running, independent of any LED's mode
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (boundary) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + BLINK_W'(1);
      end
    end
  end

  // Breathe step prescaler (counts period boundaries)
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      stepCnt <= '0;
    end else if (boundary) begin
      stepCnt <= (stepCnt == STEP_LAST) ? '0 : stepCnt + STEP_W'(1);
    end
  end

  // Breathe FSM: state register
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      brState <= BR_UP;
      brLevel <= '0;
    end else begin
      brState <= brStateNext;
      brLevel <= brLevelNext;
    end
  end

  // Breathe FSM: next state. Direction flips on the step that reaches the
  // end value, so 15 and 0 are each held for exactly one step.
  always_comb begin
    brStateNext = brState;
    if (brStep) begin
      case (brState)
        BR_UP:   if (brLevel == PWM_W'(14)) brStateNext = BR_DOWN;
        BR_DOWN: if (brLevel == PWM_W'(1))  brStateNext = BR_UP;
        default: brStateNext = BR_UP;
      endcase
    end
  end

  // Breathe FSM: level output
  always_comb begin
    brLevelNext = brLevel;
    if (brStep) begin
      case (brState)
        BR_UP:   brLevelNext = brLevel + PWM_W'(1);
        BR_DOWN: brLevelNext = brLevel - PWM_W'(1);
        default: brLevelNext = '0;
      endcase
    end
  end

  // Config handshake. At a boundary the shadow drains into the active set
  // and a request arriving in that same cycle refills the shadow.
  assign cfgAccept = iCfgVld && (!oCfgBusy || boundary);

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      shadowMode <= '0;
      shadowDuty <= '0;
      activeDuty <= '0;
      oCfgBusy   <= 1'b0;
      for (int unsigned i = 0; i < LED_CNT; i++) begin
        activeMode[i] <= LED_OFF;
      end
    end else begin
      if (boundary && oCfgBusy) begin
        activeDuty <= shadowDuty;
        for (int unsigned i = 0; i < LED_CNT; i++) begin
          activeMode[i] <= ledMode_t'(shadowMode[2*i +: 2]);
        end
      end
      if (cfgAccept) begin
        shadowMode <= iLedMode;
        shadowDuty <= iLedDuty;
        oCfgBusy   <= 1'b1;
      end else if (boundary) begin
        oCfgBusy <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < LED_CNT; g++) begin : gCh
    led_pwm_ch uCh (
      .iSysClk     (iSysClk),
      .iSysRst     (iSysRst),
      .iMode       (activeMode[g]),
      .iDuty       (activeDuty),
      .iBrLevel    (brLevel),
      .iBlinkPhase (blinkPhase),
      .iPwmCnt     (pwmCnt),
      .oLed        (oUserLed[g])
    );
  end

endmodule

// File: tb/tb_user_led_driver.sv
module tb_user_led_driver;

  localparam int TICK  = 2;
  localparam int BLINK = 2;
  localparam int STEP  = 1;
  localparam int PER   = TICK * 16;

  logic       iSysClk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] iLedMode = '0;
  logic [3:0] iLedDuty = '0;
  logic       iCfgVld = 1'b0;
  logic       oCfgBusy;
  logic [3:0] oUserLed;

  user_led_driver #(
    .pTickDiv      (TICK),
    .pBlinkPeriods (BLINK),
    .pBreathStep   (STEP)
  ) dut (
    .iSysClk  (iSysClk),
    .iSysRst  (rstN),
    .iLedMode (iLedMode),
    .iLedDuty (iLedDuty),
    .iCfgVld  (iCfgVld),
    .oCfgBusy (oCfgBusy),
    .oUserLed (oUserLed)
  );

  always #5 iSysClk = ~iSysClk;

  int nPass = 0;
  int nChecks = 0;
  logic chkEn = 1'b0;
  int hiCnt[4];

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Everything derives from n = clock edges since reset release.
  function automatic int triLevel(input int k);
    int m = k % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  function automatic logic [3:0] modelLeds(input int n, input logic [7:0] mode,
                                           input logic [3:0] duty);
    int pwm   = (n / TICK) % 16;
    int per   = n / PER;
    int phase = (per / BLINK) % 2;
    int lvl   = triLevel(per / STEP);
    logic [3:0] r = '0;
    logic [1:0] m;
    for (int l = 0; l < 4; l++) begin
      m = mode[2*l +: 2];
      case (m)
        2'b01:   r[l] = (pwm < int'(duty));
        2'b10:   r[l] = (pwm < int'(duty)) && (phase == 1);
        2'b11:   r[l] = (pwm < lvl);
        default: r[l] = 1'b0;
      endcase
    end
    return r;
  endfunction

  int         mN = 0;
  logic [7:0] mActMode = '0, mShMode = '0;
  logic [3:0] mActDuty = '0, mShDuty = '0;
  logic       mBusy = 1'b0;
  logic [3:0] mExpLed = '0;

  always @(posedge iSysClk or negedge rstN) begin
    if (!rstN) begin
      mN <= 0; mActMode <= '0; mActDuty <= '0; mShMode <= '0; mShDuty <= '0;
      mBusy <= 1'b0; mExpLed <= '0;
    end else begin
      mExpLed <= modelLeds(mN, mActMode, mActDuty);
      if (((mN + 1) % PER == 0) && mBusy) begin
        mActMode <= mShMode;
        mActDuty <= mShDuty;
      end
      if (iCfgVld && (!mBusy || ((mN + 1) % PER == 0))) begin
        mShMode <= iLedMode;
        mShDuty <= iLedDuty;
        mBusy   <= 1'b1;
      end else if ((mN + 1) % PER == 0) begin
        mBusy <= 1'b0;
      end
      mN <= mN + 1;
    end
  end

  always @(negedge iSysClk) begin
    if (chkEn) begin
      check("ledCycle", int'(oUserLed), int'(mExpLed));
      check("busyCycle", int'(oCfgBusy), int'(mBusy));
    end
  end

  // ---------------- helpers ----------------
  task automatic doReset();
    chkEn = 1'b0;
    @(negedge iSysClk);
    rstN = 1'b0;
    iCfgVld = 1'b0;
    repeat (3) @(negedge iSysClk);
    rstN = 1'b1;
    chkEn = 1'b1;
  endtask

  task automatic cfg(input logic [7:0] mode, input logic [3:0] duty);
    iLedMode = mode;
    iLedDuty = duty;
    iCfgVld  = 1'b1;
    @(negedge iSysClk);
    iCfgVld  = 1'b0;
  endtask

  task automatic waitApplied();
    int k = 0;
    while (oCfgBusy && k < 200) begin
      @(negedge iSysClk);
      k++;
    end
    check("applyTimeout", int'(oCfgBusy), 0);
  endtask

  task automatic countPeriod();
    for (int l = 0; l < 4; l++) hiCnt[l] = 0;
    for (int c = 0; c < PER; c++) begin
      @(negedge iSysClk);
      for (int l = 0; l < 4; l++) hiCnt[l] += int'(oUserLed[l]);
    end
  endtask

  typedef struct {
    logic [7:0]      mode;
    logic [3:0]      duty;
    logic [3:0][7:0] expHigh;   // clocks high per period, per LED
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{mode: 8'h55, duty: 4'd8,  expHigh: {8'd16, 8'd16, 8'd16, 8'd16}};
    vecs[1] = '{mode: 8'h55, duty: 4'd0,  expHigh: {8'd0,  8'd0,  8'd0,  8'd0}};
    vecs[2] = '{mode: 8'h55, duty: 4'd15, expHigh: {8'd30, 8'd30, 8'd30, 8'd30}};
    vecs[3] = '{mode: 8'h11, duty: 4'd5,  expHigh: {8'd0,  8'd10, 8'd0,  8'd10}};
    vecs[4] = '{mode: 8'h00, duty: 4'd15, expHigh: {8'd0,  8'd0,  8'd0,  8'd0}};
    vecs[5] = '{mode: 8'h41, duty: 4'd1,  expHigh: {8'd2,  8'd0,  8'd0,  8'd2}};

    doReset();
    check("resetLed", int'(oUserLed), 0);
    check("resetBusy", int'(oCfgBusy), 0);

    // Table: static ON/OFF patterns measured over one full period
    for (int v = 0; v < 6; v++) begin
      cfg(vecs[v].mode, vecs[v].duty);
      check("busyAfterVld", int'(oCfgBusy), 1);
      waitApplied();
      countPeriod();
      for (int l = 0; l < 4; l++) check("tableHigh", hiCnt[l], int'(vecs[v].expHigh[l]));
    end

    // Second request while busy is dropped
    doReset();
    cfg(8'h55, 4'd8);
    check("busyFirst", int'(oCfgBusy), 1);
    cfg(8'h55, 4'd3);
    waitApplied();
    countPeriod();
    for (int l = 0; l < 4; l++) check("ignoredWhileBusy", hiCnt[l], 16);

    // Request landing exactly on the boundary cycle is accepted
    doReset();
    cfg(8'h55, 4'd2);
    repeat (30) @(negedge iSysClk);
    cfg(8'h55, 4'd12);
    check("boundaryAccept", int'(oCfgBusy), 1);
    waitApplied();
    countPeriod();
    for (int l = 0; l < 4; l++) check("boundaryApplied", hiCnt[l], 24);

    // Blink on LED0: first applied period is P=1 (dark), P=2,3 lit, P=4 dark
    doReset();
    cfg(8'h02, 4'd15);
    waitApplied();
    for (int p = 0; p < 4; p++) begin
      countPeriod();
      check("blinkLed0", hiCnt[0], (p == 1 || p == 2) ? 30 : 0);
      check("blinkOthers", hiCnt[1] + hiCnt[2] + hiCnt[3], 0);
    end

    // Breathe: per-period high clocks = 2 * level, level is a 0..15..0 triangle
    doReset();
    cfg(8'hFF, 4'd0);
    waitApplied();
    for (int j = 0; j < 34; j++) begin
      countPeriod();
      check("breatheLed0", hiCnt[0], 2 * triLevel(j + 1));
      check("breatheLed3", hiCnt[3], 2 * triLevel(j + 1));
    end

    // Reset mid-breathe with a pending config: outputs drop inside the cycle
    cfg(8'h55, 4'd4);
    repeat (3) @(negedge iSysClk);
    chkEn = 1'b0;
    @(posedge iSysClk);
    #1 rstN = 1'b0;
    #1;
    check("asyncRstLed", int'(oUserLed), 0);
    check("asyncRstBusy", int'(oCfgBusy), 0);
    @(negedge iSysClk);
    rstN = 1'b1;
    chkEn = 1'b1;
    // Pending duty-4 config was discarded: LEDs stay dark after a boundary
    repeat (PER + 2) @(negedge iSysClk);
    check("pendingDropped", int'(oUserLed), 0);
    doReset();
    cfg(8'hFF, 4'd0);
    waitApplied();
    countPeriod();
    check("breatheRestart1", hiCnt[0], 2);
    countPeriod();
    check("breatheRestart2", hiCnt[0], 4);

    // Randomized traffic against the model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      iLedMode = 8'($urandom);
      iLedDuty = 4'($urandom);
      iCfgVld  = ($urandom_range(0, 5) == 0);
      @(negedge iSysClk);
    end
    iCfgVld = 1'b0;
    @(negedge iSysClk);
    chkEn = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
